jamma_input_scanner: RTL and testbench

- Parametrised successor to the two-way JAMMA joystick splitter used in the arcade top levels.
- Drives the external splitter select lines and time-multiplexes one shared JJOY bus across NUM_PLAYERS players. Each player's sample is taken only after a programmable settle time and then debounced.
- Synchronises the coin inputs, filters them and stretches them into clean pulses for the core.
- Sits between the JAMMA connector pins and the arcade core's I_JOYSTICK_x, I_PLAYER and I_COIN inputs.

---
 rtl/jamma_input_scanner.sv | 97 +++++++++
 tb/tb_jamma_input_scanner.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/jamma_input_scanner.sv
// jamma_input_scanner: scans a shared JAMMA joystick bus per player with settle/debounce, and filters/stretches the coin inputs.
module jamma_input_scanner #(
  parameter int NUM_PLAYERS  = 2,
  parameter int JOY_W        = 8,
  parameter int SEL_W        = 1,
  parameter int SETTLE_CYC   = 4,
  parameter int DEBOUNCE_N   = 3,
  parameter int COIN_W       = 2,
  parameter int COIN_STRETCH = 16
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         CLK_EN,
  input  logic [JOY_W-1:0]             JJOY,
  input  logic [JOY_W-1:0]             JOYSTICK_LOCAL,
  input  logic [COIN_W-1:0]            JCOIN,
  output logic [SEL_W-1:0]             JSELECT,
  output logic [NUM_PLAYERS*JOY_W-1:0] JOY_OUT,
  output logic [COIN_W-1:0]            COIN_OUT,
  output logic                         SCAN_DONE
);
  localparam logic [0:0] SETTLE = 1'b0;
  localparam logic [0:0] SAMPLE = 1'b1;
  logic [0:0]       state;
  logic [7:0]       slot_cnt;
  logic [JOY_W-1:0] cand [NUM_PLAYERS];
  logic [3:0]       db_cnt [NUM_PLAYERS];
  logic [JOY_W-1:0] smp, cur_cand;
  logic [3:0]       cur_cnt, new_cnt;
  logic             last, take;
  logic [COIN_W-1:0] sync1, sync2, prev, fall;
  logic [15:0]      str_cnt [COIN_W];
  logic [15:0]      str_nxt [COIN_W];
  always_comb begin
    cur_cand = '1;
    cur_cnt = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (JSELECT == SEL_W'(i)) begin
        cur_cand = cand[i];
        cur_cnt = db_cnt[i];
      end
    smp = JJOY & ((JSELECT == '0) ? JOYSTICK_LOCAL : '1);
    new_cnt = (smp != cur_cand) ? 4'd1 : (cur_cnt == 4'hF) ? cur_cnt : cur_cnt + 4'd1;
    last = JSELECT == SEL_W'(NUM_PLAYERS - 1);
    take = CLK_EN && state == SAMPLE;
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state <= SETTLE;
      slot_cnt <= '0;
      JSELECT <= '0;
      SCAN_DONE <= 1'b0;
    end else begin
      SCAN_DONE <= take && last;
      if (CLK_EN) begin
        state <= (state == SETTLE && slot_cnt == 8'(SETTLE_CYC - 1)) ? SAMPLE : SETTLE;
        slot_cnt <= (state == SETTLE && slot_cnt != 8'(SETTLE_CYC - 1)) ? slot_cnt + 8'd1 : '0;
        if (state == SAMPLE) JSELECT <= last ? '0 : JSELECT + 1'b1;
      end
    end
  // candidate, run length and output all commit on the SAMPLE edge of the selected player
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      JOY_OUT <= '1;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        cand[i] <= '1;
        db_cnt[i] <= '0;
      end
    end else if (take)
      for (int i = 0; i < NUM_PLAYERS; i++)
        if (JSELECT == SEL_W'(i)) begin
          cand[i] <= smp;
          db_cnt[i] <= new_cnt;
          if (new_cnt >= 4'(DEBOUNCE_N)) JOY_OUT[i*JOY_W +: JOY_W] <= smp;
        end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) {sync2, sync1} <= '1;
    else {sync2, sync1} <= {sync1, JCOIN};
  always_comb begin
    fall = prev & ~sync2;
    for (int i = 0; i < COIN_W; i++)
      str_nxt[i] = fall[i] ? 16'(COIN_STRETCH) : (str_cnt[i] != '0) ? str_cnt[i] - 16'd1 : '0;
  end
  // edge history only advances on enabled cycles so a press during a stall is not lost
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      prev <= '1;
      COIN_OUT <= '1;
      for (int i = 0; i < COIN_W; i++) str_cnt[i] <= '0;
    end else if (CLK_EN) begin
      prev <= sync2;
      for (int i = 0; i < COIN_W; i++) begin
        str_cnt[i] <= str_nxt[i];
        COIN_OUT[i] <= (str_nxt[i] == '0) && sync2[i];
      end
    end
endmodule

// File: tb/tb_jamma_input_scanner.sv
// tb_jamma_input_scanner: directed literal checks plus randomized traffic against a slot-arithmetic reference model.
module tb_jamma_input_scanner;
  localparam int NP = 2, JW = 8, SW = 1, SC = 4, DN = 3, CW = 2, CS = 16;
  logic CLK = 1'b0, RESET_N = 1'b1, CLK_EN = 1'b1;
  logic [JW-1:0] pad [NP];
  logic [JW-1:0] JJOY, JOYSTICK_LOCAL;
  logic [CW-1:0] JCOIN;
  logic [SW-1:0] JSELECT;
  logic [NP*JW-1:0] JOY_OUT, exp_joy;
  logic [CW-1:0] COIN_OUT;
  logic SCAN_DONE;
  int checks = 0, errors = 0;
  logic go = 1'b0;
  int en_n, mpos, mpl;
  logic [JW-1:0] last_s [NP];
  logic [JW-1:0] m_joy [NP];
  logic [JW-1:0] ms;
  int run [NP];
  logic m_done;
  logic [CW-1:0] d1, d2, mprev, m_coin;
  int press_at [CW];

  jamma_input_scanner #(.NUM_PLAYERS(NP), .JOY_W(JW), .SEL_W(SW), .SETTLE_CYC(SC),
    .DEBOUNCE_N(DN), .COIN_W(CW), .COIN_STRETCH(CS)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CLK_EN(CLK_EN), .JJOY(JJOY),
    .JOYSTICK_LOCAL(JOYSTICK_LOCAL), .JCOIN(JCOIN), .JSELECT(JSELECT),
    .JOY_OUT(JOY_OUT), .COIN_OUT(COIN_OUT), .SCAN_DONE(SCAN_DONE));

  assign JJOY = pad[JSELECT];
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: slot position and player follow from the count of enabled edges
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      en_n = 0;
      m_done = 1'b0;
      d1 = '1;
      d2 = '1;
      mprev = '1;
      m_coin = '1;
      for (int p = 0; p < NP; p++) begin
        last_s[p] = '1;
        run[p] = 0;
        m_joy[p] = '1;
      end
      for (int b = 0; b < CW; b++) press_at[b] = -1000000;
    end else begin
      if (CLK_EN) begin
        mpos = en_n % (SC + 1);
        mpl = (en_n / (SC + 1)) % NP;
        if (mpos == SC) begin
          ms = pad[mpl] & ((mpl == 0) ? JOYSTICK_LOCAL : 8'hFF);
          if (ms == last_s[mpl]) run[mpl]++;
          else begin
            last_s[mpl] = ms;
            run[mpl] = 1;
          end
          if (run[mpl] >= DN) m_joy[mpl] = ms;
        end
        m_done = (mpos == SC) && (mpl == NP - 1);
        for (int b = 0; b < CW; b++) begin
          if (mprev[b] && !d2[b]) press_at[b] = en_n;
          mprev[b] = d2[b];
          m_coin[b] = !(!d2[b] || (en_n - press_at[b]) < CS);
        end
        en_n++;
      end else m_done = 1'b0;
      d2 = d1;
      d1 = JCOIN;
    end
  end

  always @(negedge CLK) if (go) begin
    for (int p = 0; p < NP; p++) exp_joy[p*JW +: JW] = m_joy[p];
    chk("model_jsel", 32'(JSELECT), (en_n / (SC + 1)) % NP);
    chk("model_joy", 32'(JOY_OUT), 32'(exp_joy));
    chk("model_coin", 32'(COIN_OUT), 32'(m_coin));
    chk("model_done", 32'(SCAN_DONE), 32'(m_done));
  end

  task automatic do_reset;
    @(negedge CLK);
    #2 RESET_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    go = 1'b1;
  endtask

  initial begin
    pad[0] = 8'hFE;
    pad[1] = 8'hFF;
    JOYSTICK_LOCAL = 8'hFF;
    JCOIN = '1;
    #1 RESET_N = 1'b0;
    do_reset;
    for (int c = 0; c <= 30; c++) begin
      chk("jsel_scan", 32'(JSELECT), (c % 10 < 5) ? 0 : 1);
      chk("done_scan", 32'(SCAN_DONE), (c == 10 || c == 20 || c == 30) ? 1 : 0);
      chk("joy0_debounce", 32'(JOY_OUT[7:0]), (c >= 25) ? 32'hFE : 32'hFF);
      chk("joy1_idle", 32'(JOY_OUT[15:8]), 32'hFF);
      @(negedge CLK);
    end
    pad[0] = 8'hFE;
    do_reset;
    for (int c = 0; c <= 30; c++) begin
      if (c == 5) pad[0] = 8'hFF;
      chk("joy0_glitch", 32'(JOY_OUT[7:0]), 32'hFF);
      @(negedge CLK);
    end
    JOYSTICK_LOCAL = 8'hEF;
    do_reset;
    for (int c = 0; c <= 25; c++) begin
      if (c == 24) chk("joy0_local_pre", 32'(JOY_OUT[7:0]), 32'hFF);
      if (c == 25) begin
        chk("joy0_local", 32'(JOY_OUT[7:0]), 32'hEF);
        chk("joy1_local", 32'(JOY_OUT[15:8]), 32'hFF);
      end
      @(negedge CLK);
    end
    JOYSTICK_LOCAL = 8'hFF;
    do_reset;
    for (int c = 0; c <= 45; c++) begin
      if (c == 0) JCOIN = 2'b00;
      if (c == 2) JCOIN[0] = 1'b1;
      if (c == 40) JCOIN[1] = 1'b1;
      chk("coin0_stretch", 32'(COIN_OUT[0]), (c >= 3 && c <= 18) ? 0 : 1);
      chk("coin1_hold", 32'(COIN_OUT[1]), (c >= 3 && c <= 42) ? 0 : 1);
      @(negedge CLK);
    end
    pad[0] = 8'hFE;
    pad[1] = 8'h7F;
    do_reset;
    for (int c = 0; c <= 76; c++) begin
      CLK_EN = (c % 2 == 0);
      chk("done_gated", 32'(SCAN_DONE), (c == 19 || c == 39 || c == 59) ? 1 : 0);
      chk("jsel_gated", 32'(JSELECT), ((c + 1) / 2 / 5) % 2);
      if (c == 76) chk("joy_gated", 32'(JOY_OUT), 32'h7FFE);
      if (c < 76) @(negedge CLK);
    end
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_jsel", 32'(JSELECT), 0);
    chk("rst_joy", 32'(JOY_OUT), 32'hFFFF);
    chk("rst_done", 32'(SCAN_DONE), 0);
    chk("rst_coin", 32'(COIN_OUT), 32'h3);
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    CLK_EN = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      chk("jsel_restart", 32'(JSELECT), (c % 10 < 5) ? 0 : 1);
      @(negedge CLK);
    end
    do_reset;
    for (int c = 0; c < 3000; c++) begin
      CLK_EN = ($urandom % 4) != 0;
      for (int p = 0; p < NP; p++)
        if ($urandom % 40 == 0) pad[p] = ($urandom % 3 == 0) ? 8'hFF : 8'($urandom);
      if ($urandom % 100 == 0) JOYSTICK_LOCAL = ($urandom % 2 == 0) ? 8'hFF : 8'($urandom);
      for (int b = 0; b < CW; b++)
        if ($urandom % 20 == 0) JCOIN[b] = ~JCOIN[b];
      if ($urandom % 700 == 0) begin
        #2 RESET_N = 1'b0;
        #1 RESET_N = 1'b1;
      end
      @(negedge CLK);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
